// File: rtl/regfile_pkg.sv
// Shared definitions for the multiport register file.
//   DATA_W_DEF / ADDR_W_DEF : default register width and address width
//   clr_state_e             : clear-sequencer state (IDLE, CLEAR)
//   depth_f()               : entry count for a given address width
package regfile_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    function automatic int depth_f(input int addr_w);
        return 1 << addr_w;
    endfunction
endpackage

// File: rtl/regfile_multiport_if.sv
// Bus bundle between the pipeline (master) and the register file (slave).
//   RdEn/RdAddr  -> per-port read request, port p address at [p*ADDR_W +: ADDR_W]
//   RdData/RdValid <- per-port registered read result, port p at [p*DATA_W +: DATA_W]
//   WrEn/WrAddr/WrData -> single write port
//   ClrReq -> start a hardware clear;  Busy <- clear in progress
interface regfile_multiport_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2
);
    logic [NUM_RD-1:0]        RdEn;
    logic [NUM_RD*ADDR_W-1:0] RdAddr;
    logic [NUM_RD*DATA_W-1:0] RdData;
    logic [NUM_RD-1:0]        RdValid;
    logic                     WrEn;
    logic [ADDR_W-1:0]        WrAddr;
    logic [DATA_W-1:0]        WrData;
    logic                     ClrReq;
    logic                     Busy;

    modport master (
        output RdEn, RdAddr, WrEn, WrAddr, WrData, ClrReq,
        input  RdData, RdValid, Busy
    );

    modport slave (
        input  RdEn, RdAddr, WrEn, WrAddr, WrData, ClrReq,
        output RdData, RdValid, Busy
    );
endinterface

// File: rtl/regfile_clear_ctrl.sv
// Clear sequencer: walks a pointer over every entry, one per cycle, and
// presents a zero-write to the array write mux while doing so.
//   Clk, Rst  : clock, synchronous active-high reset (starts a clear)
//   ClrReq    : start a clear when idle (ignored while clearing)
//   Busy      : clear in progress
//   ClrWe     : clear write enable into the array
//   ClrAddr   : entry being cleared this cycle
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              ClrReq,
    output logic              Busy,
    output logic              ClrWe,
    output logic [ADDR_W-1:0] ClrAddr
);
    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (ClrReq) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            ST_CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                // Last entry is cleared on this edge; pointer wraps to 0.
                if (&ptr_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        Busy    = (state_q == ST_CLEAR);
        ClrWe   = Busy;
        ClrAddr = ptr_q;
    end
endmodule

// File: rtl/regfile_multiport.sv
// Parametrised multiport register file with registered reads.
//   Clk, Rst : clock, synchronous active-high reset (triggers a full clear)
//   bus      : regfile_multiport_if slave (read ports, write port, clear, busy)
// Build option: REGFILE_BYPASS_EN -- when defined, a read of the address being
// written on the same edge returns the new data (write-before-read); otherwise
// it returns the old contents (read-before-write).
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                Clk,
    input  logic                Rst,
    regfile_multiport_if.slave  bus
);
    localparam int DEPTH = depth_f(ADDR_W);

    logic              busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    regfile_clear_ctrl #(.ADDR_W(ADDR_W)) u_clr (
        .Clk     (Clk),
        .Rst     (Rst),
        .ClrReq  (bus.ClrReq),
        .Busy    (busy),
        .ClrWe   (clr_we),
        .ClrAddr (clr_addr)
    );

    assign bus.Busy = busy;

    // User write survives only when idle, not in reset, and not aimed at a
    // hardwired-zero entry 0.
    logic usr_we;
    assign usr_we = bus.WrEn && !busy && !Rst &&
                    !((ZERO_REG != 0) && (bus.WrAddr == '0));

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    always_comb begin
        we    = usr_we;
        waddr = bus.WrAddr;
        wdata = bus.WrData;
        if (clr_we) begin
            we    = 1'b1;
            waddr = clr_addr;
            wdata = '0;
        end
    end

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge Clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              byp;
        logic              vld_q, vld_d;
        logic [DATA_W-1:0] data_q, data_d;

        assign ra = bus.RdAddr[p*ADDR_W +: ADDR_W];

`ifdef REGFILE_BYPASS_EN
        assign byp = usr_we && (bus.WrAddr == ra);
`else
        assign byp = 1'b0;
`endif

        always_comb begin
            vld_d  = 1'b0;
            data_d = data_q;
            if (!busy && bus.RdEn[p]) begin
                vld_d = 1'b1;
                if ((ZERO_REG != 0) && (ra == '0)) data_d = '0;
                else if (byp)                      data_d = bus.WrData;
                else                               data_d = mem_q[ra];
            end
        end

        always_ff @(posedge Clk) begin
            if (Rst) begin
                vld_q  <= 1'b0;
                data_q <= '0;
            end else begin
                vld_q  <= vld_d;
                data_q <= data_d;
            end
        end

        assign bus.RdValid[p]                = vld_q;
        assign bus.RdData[p*DATA_W +: DATA_W] = data_q;
    end
endmodule

// File: tb/tb_regfile_multiport.sv
module tb_regfile_multiport;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 3;
    localparam int DEPTH = 1 << AW;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Rst;
    always #5 Clk = ~Clk;

    regfile_multiport_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

    regfile_multiport #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    typedef struct packed {
        logic                   busy;
        logic [NR-1:0]          vld;
        logic [NR-1:0][DW-1:0]  data;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model: architectural view of the register file.
    logic [DW-1:0]         m_mem [DEPTH];
    int                    m_busy_left = 0;
    logic [NR-1:0]         m_vld = '0;
    logic [NR-1:0][DW-1:0] m_data = '0;

    function automatic void chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Monitor: one expected snapshot per clock edge.
    always @(posedge Clk) begin
        #1;
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("busy", {31'd0, bus.Busy}, {31'd0, e.busy});
            for (int p = 0; p < NR; p++) begin
                chk($sformatf("rdvalid[%0d]", p), {31'd0, bus.RdValid[p]}, {31'd0, e.vld[p]});
                chk($sformatf("rddata[%0d]", p), bus.RdData[p*DW +: DW], e.data[p]);
            end
        end
    end

    task automatic step(input logic rst, input logic clr, input logic we,
                        input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [NR-1:0] re, input logic [NR-1:0][AW-1:0] ra);
        @(negedge Clk);
        Rst        = rst;
        bus.ClrReq = clr;
        bus.WrEn   = we;
        bus.WrAddr = wa;
        bus.WrData = wd;
        bus.RdEn   = re;
        bus.RdAddr = ra;
        if (rst) begin
            foreach (m_mem[i]) m_mem[i] = '0;
            m_busy_left = DEPTH;
            m_vld  = '0;
            m_data = '0;
        end else if (m_busy_left > 0) begin
            m_busy_left--;
            m_vld = '0;
        end else begin
            for (int p = 0; p < NR; p++) begin
                m_vld[p] = re[p];
                if (re[p]) begin
                    if (ra[p] == 0)                          m_data[p] = '0;
                    else if (BYPASS && we && wa == ra[p])    m_data[p] = wd;
                    else                                     m_data[p] = m_mem[ra[p]];
                end
            end
            if (we && wa != 0) m_mem[wa] = wd;
            if (clr) begin
                foreach (m_mem[i]) m_mem[i] = '0;
                m_busy_left = DEPTH;
            end
        end
        exp_q.push_back('{busy: (m_busy_left > 0), vld: m_vld, data: m_data});
    endtask

    task automatic rd3(input logic [NR-1:0] re, input int a0, input int a1, input int a2);
        step(0, 0, 0, '0, '0, re, {AW'(a2), AW'(a1), AW'(a0)});
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        step(0, 0, 1, AW'(a), d, '0, '0);
    endtask

    task automatic junk(input logic clr_ok);
        step(0, clr_ok & ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
             AW'($urandom), $urandom, NR'($urandom),
             {AW'($urandom), AW'($urandom), AW'($urandom)});
    endtask

    initial begin
        Rst = 1'b0;
        bus.ClrReq = 1'b0;
        bus.WrEn   = 1'b0;
        bus.WrAddr = '0;
        bus.WrData = '0;
        bus.RdEn   = '0;
        bus.RdAddr = '0;

        // Reset pulse, then random traffic while the clear runs (must be ignored).
        step(1, 0, 0, '0, '0, '0, '0);
        repeat (DEPTH) junk(1'b1);
        for (int a = 0; a < DEPTH; a++) rd3('1, a, a, (a + 1) % DEPTH);

        wr(5, 32'hDEADBEEF);
        rd3(3'b011, 5, 5, 0);
        wr(0, 32'h12345678);
        rd3(3'b111, 0, 0, 5);

        // Same-edge write/read of address 7.
        wr(7, 32'h1);
        step(0, 0, 1, AW'(7), 32'h2, 3'b111, {AW'(7), AW'(7), AW'(7)});
        rd3(3'b111, 7, 7, 7);

        // Port 1 must hold its previous value when not enabled.
        wr(1, 32'hAAAA0001);
        wr(2, 32'hBBBB0002);
        rd3(3'b111, 5, 7, 5);
        rd3(3'b101, 1, 2, 1);
        rd3(3'b000, 1, 2, 1);

        // ClrReq, then Rst ten cycles later, WrEn high throughout.
        step(0, 1, 1, AW'(9), 32'hCAFE0009, '0, '0);
        for (int i = 0; i < 9; i++) step(0, 0, 1, AW'(i + 3), $urandom, '0, '0);
        step(1, 0, 1, AW'(10), 32'hF00DF00D, '0, '0);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, AW'(i), $urandom, '0, '0);
        rd3(3'b111, 9, 10, 5);
        rd3(3'b111, 3, 31, 1);

        // Randomised traffic with collision-prone addresses.
        for (int i = 0; i < 600; i++) begin
            logic r, c;
            r = ($urandom_range(0, 249) == 0);
            c = ($urandom_range(0, 79) == 0);
            step(r, c, $urandom_range(0, 1), AW'($urandom_range(0, 7)), $urandom,
                 NR'($urandom),
                 {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))});
        end
        step(0, 0, 0, '0, '0, '0, '0);

        begin
            int waited;
            waited = 0;
            while (exp_q.size() != 0 && waited < 20) begin
                @(negedge Clk);
                waited++;
            end
            chk("scoreboard_drain", DW'(exp_q.size()), '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
